// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_CH byte producers, up to MAX_BURST bytes per grant.
// Optional UART_ARB_HDR_EN: each grant is prefixed by a header byte {HDR_TAG, channel}.
module uart_tx_arbiter #(
  parameter int N_CH      = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 0
`ifdef UART_ARB_HDR_EN
  ,
  parameter logic [3:0] HDR_TAG = 4'hA
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_CH-1:0]   i_req_valid,
  input  logic [N_CH*8-1:0] i_req_data,
  output logic [N_CH-1:0]   o_req_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [N_CH-1:0]   o_grant,
  output logic              o_busy,
  output logic              o_timeout
);
  localparam int            PW        = $clog2(N_CH);
  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [8:0]    BURST_LIM = 9'(MAX_BURST);
  localparam logic [PW-1:0] LAST_CH   = PW'(N_CH - 1);

`ifdef UART_ARB_HDR_EN
  typedef enum logic [1:0] {IDLE, HDR, LOAD, WAIT} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_e;
`endif

  state_e          state_q;
  logic [PW-1:0]   ptr_q, gidx_q;
  logic [7:0]      burst_q;
  logic [TW-1:0]   wait_q;
  logic [N_CH-1:0] grant_q, req_ready_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q, timeout_q;

  // First valid channel at or after ptr_q, wrapping.
  logic [PW-1:0] gnt_d;
  logic          any_d;
  logic [PW:0]   scan;
  always_comb begin
    gnt_d = ptr_q;
    any_d = 1'b0;
    scan  = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan >= (PW+1)'(N_CH)) scan = scan - (PW+1)'(N_CH);
      if (!any_d && i_req_valid[scan[PW-1:0]]) begin
        gnt_d = scan[PW-1:0];
        any_d = 1'b1;
      end
    end
  end

  logic [8:0]    burst_nx;
  logic          more_d, tmo_hit;
  logic [PW-1:0] next_ptr;
  assign burst_nx = {1'b0, burst_q} + 9'd1;
  assign more_d   = i_req_valid[gidx_q] && (burst_nx < BURST_LIM);
  assign tmo_hit  = (TIMEOUT > 0) && (wait_q == TO_LAST);
  assign next_ptr = (gidx_q == LAST_CH) ? '0 : gidx_q + 1'b1;

  // o_req_ready pulses during LOAD, the same cycle the byte is sampled, so the
  // producer has already advanced by the time WAIT looks at its valid again.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      burst_q     <= '0;
      wait_q      <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      req_ready_q <= '0;
      timeout_q   <= 1'b0;
      case (state_q)
        IDLE: if (any_d) begin
          gidx_q  <= gnt_d;
          grant_q <= N_CH'(1) << gnt_d;
`ifdef UART_ARB_HDR_EN
          tx_data_q  <= {HDR_TAG, 4'(gnt_d)};
          tx_valid_q <= 1'b1;
          wait_q     <= '0;
          state_q    <= HDR;
`else
          req_ready_q <= N_CH'(1) << gnt_d;
          state_q     <= LOAD;
`endif
        end
`ifdef UART_ARB_HDR_EN
        HDR: if (i_tx_ready) begin
          tx_valid_q <= 1'b0;
          if (i_req_valid[gidx_q]) begin
            req_ready_q <= grant_q;
            state_q     <= LOAD;
          end else begin
            state_q <= IDLE;
            ptr_q   <= next_ptr;
            grant_q <= '0;
            burst_q <= '0;
          end
        end else if (tmo_hit) begin
          timeout_q  <= 1'b1;
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
          ptr_q      <= next_ptr;
          grant_q    <= '0;
          burst_q    <= '0;
        end else begin
          wait_q <= wait_q + 1'b1;
        end
`endif
        LOAD: begin
          tx_data_q  <= i_req_data[{gidx_q, 3'b000} +: 8];
          tx_valid_q <= 1'b1;
          wait_q     <= '0;
          state_q    <= WAIT;
        end
        WAIT: if (i_tx_ready) begin
          tx_valid_q <= 1'b0;
          if (more_d) begin
            burst_q     <= burst_nx[7:0];
            req_ready_q <= grant_q;
            state_q     <= LOAD;
          end else begin
            state_q <= IDLE;
            ptr_q   <= next_ptr;
            grant_q <= '0;
            burst_q <= '0;
          end
        end else if (tmo_hit) begin
          timeout_q  <= 1'b1;
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
          ptr_q      <= next_ptr;
          grant_q    <= '0;
          burst_q    <= '0;
        end else begin
          wait_q <= wait_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_grant     = grant_q;
  assign o_busy      = (state_q != IDLE);
  assign o_timeout   = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue producers, a uart_tx ready model and an expected-byte scoreboard.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef UART_ARB_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  // index 0: MAX_BURST=4 TIMEOUT=16, index 1: MAX_BURST=1 TIMEOUT=0
  logic [3:0]  req_valid [2];
  logic [31:0] req_data  [2];
  logic        tx_ready  [2];
  logic [3:0]  req_ready [2];
  logic [7:0]  tx_data   [2];
  logic        tx_valid  [2];
  logic [3:0]  grant     [2];
  logic        busy      [2];
  logic        tmo       [2];

  uart_tx_arbiter #(.N_CH(4), .MAX_BURST(4), .TIMEOUT(16)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid[0]), .i_req_data(req_data[0]),
    .o_req_ready(req_ready[0]), .o_tx_data(tx_data[0]), .o_tx_valid(tx_valid[0]),
    .i_tx_ready(tx_ready[0]), .o_grant(grant[0]), .o_busy(busy[0]), .o_timeout(tmo[0]));

  uart_tx_arbiter #(.N_CH(4), .MAX_BURST(1), .TIMEOUT(0)) u_rr (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid[1]), .i_req_data(req_data[1]),
    .o_req_ready(req_ready[1]), .o_tx_data(tx_data[1]), .o_tx_valid(tx_valid[1]),
    .i_tx_ready(tx_ready[1]), .o_grant(grant[1]), .o_busy(busy[1]), .o_timeout(tmo[1]));

  logic [7:0]  pmem   [2][4][32];
  int          ph     [2][4];
  int          pt     [2][4];
  int          rr_cnt [2][4];
  logic [3:0]  pend   [2];
  int          dly    [2];
  int          wcnt   [2];
  logic [12:0] expq   [$];
  logic [12:0] got, sb_e;
  int          nchk = 0;
  int          nfail = 0;

  function automatic int oh2i(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 15;
    endcase
  endfunction

  // Producers pop one cycle after their ready pulse; uart model answers after dly cycles (0 = never).
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        if (pend[d][k] && ph[d][k] != pt[d][k]) ph[d][k] = ph[d][k] + 1;
        if (req_ready[d][k]) begin
          rr_cnt[d][k] = rr_cnt[d][k] + 1;
          nchk = nchk + 1;
          if (pend[d][k] || grant[d] !== (4'b0001 << k)) begin
            nfail = nfail + 1;
            $display("FAIL req_ready_pulse dut%0d ch%0d: repeat=%0b grant=%b, required single pulse under grant %b",
                     d, k, pend[d][k], grant[d], 4'b0001 << k);
          end
        end
        req_valid[d][k] = (ph[d][k] != pt[d][k]);
        req_data[d][8*k +: 8] = req_valid[d][k] ? pmem[d][k][ph[d][k] % 32] : 8'h00;
      end
      pend[d] = req_ready[d];
      if (tx_ready[d]) begin
        tx_ready[d] = 1'b0;
      end else if (tx_valid[d] && dly[d] > 0) begin
        wcnt[d] = wcnt[d] + 1;
        if (wcnt[d] >= dly[d]) begin
          wcnt[d] = 0;
          tx_ready[d] = 1'b1;
          got = {d[0], 4'(oh2i(grant[d])), tx_data[d]};
          nchk = nchk + 1;
          if (expq.size() == 0) begin
            nfail = nfail + 1;
            $display("FAIL tx_byte dut%0d: got ch%0d data %h, required no byte", d, got[11:8], got[7:0]);
          end else begin
            sb_e = expq.pop_front();
            if (got !== sb_e) begin
              nfail = nfail + 1;
              $display("FAIL tx_byte dut%0d: got dut%0d ch%0d data %h, required dut%0d ch%0d data %h",
                       d, got[12], got[11:8], got[7:0], sb_e[12], sb_e[11:8], sb_e[7:0]);
            end
          end
        end
      end else begin
        wcnt[d] = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input int d, input int k, input logic [7:0] b);
    pmem[d][k][pt[d][k] % 32] = b;
    pt[d][k] = pt[d][k] + 1;
  endtask

  task automatic exp_byte(input int d, input int k, input logic [7:0] b);
    expq.push_back({1'(d), 4'(k), b});
  endtask

  task automatic exp_hdr(input int d, input int k);
    if (HDR_EN) expq.push_back({1'(d), 4'(k), 4'hA, 4'(k)});
  endtask

  task automatic clear_prod(input int d);
    for (int k = 0; k < 4; k++) ph[d][k] = pt[d][k];
  endtask

  function automatic bit pending(input int d);
    bit p = (expq.size() != 0) || busy[d];
    for (int k = 0; k < 4; k++) if (ph[d][k] != pt[d][k]) p = 1'b1;
    return p;
  endfunction

  task automatic wait_done(input int d, input int budget, input string name);
    int n = 0;
    while (pending(d) && n < budget) begin
      tick();
      n++;
    end
    nchk++;
    if (pending(d)) begin
      nfail++;
      $display("FAIL %s_drain: busy=%0b after %0d cycles with %0d bytes outstanding, required idle",
               name, busy[d], n, expq.size());
    end
    nchk++;
    if (grant[d] !== 4'b0000) begin
      nfail++;
      $display("FAIL %s_grant_idle: grant=%b, required 0000", name, grant[d]);
    end
  endtask

  task automatic wait_valid(input int d, input string name);
    int n = 0;
    while (!tx_valid[d] && n < 20) begin
      tick();
      n++;
    end
    nchk++;
    if (!tx_valid[d]) begin
      nfail++;
      $display("FAIL %s_valid: tx_valid=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({req_ready[d], tx_data[d], tx_valid[d], grant[d], busy[d], tmo[d]} !== 19'd0) begin
        nfail++;
        $display("FAIL reset_outputs dut%0d: req_ready=%b data=%h valid=%b grant=%b busy=%b tmo=%b, required all 0",
                 d, req_ready[d], tx_data[d], tx_valid[d], grant[d], busy[d], tmo[d]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int lat = 0;
    int base = rr_cnt[0][2];
    dly[0] = 3;
    push_byte(0, 2, 8'h55);
    exp_hdr(0, 2);
    exp_byte(0, 2, 8'h55);
    tick();
    while (!tx_valid[0] && lat < 10) begin
      tick();
      lat++;
    end
    nchk++;
    if (lat != (HDR_EN ? 1 : 2)) begin
      nfail++;
      $display("FAIL single_latency: %0d cycles, required %0d", lat, HDR_EN ? 1 : 2);
    end
    nchk++;
    if (grant[0] !== 4'b0100) begin
      nfail++;
      $display("FAIL single_grant: grant=%b, required 0100", grant[0]);
    end
    wait_done(0, 100, "single");
    nchk++;
    if (rr_cnt[0][2] - base != 1) begin
      nfail++;
      $display("FAIL single_req_ready_count: %0d pulses, required 1", rr_cnt[0][2] - base);
    end
  endtask

  task automatic test_round_robin();
    dly[1] = 1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        push_byte(1, k, 8'(16 * k + i));
        exp_hdr(1, k);
        exp_byte(1, k, 8'(16 * k + i));
      end
    wait_done(1, 300, "round_robin");
    for (int k = 0; k < 4; k++) begin
      nchk++;
      if (rr_cnt[1][k] != 2) begin
        nfail++;
        $display("FAIL rr_req_ready_count ch%0d: %0d pulses, required 2", k, rr_cnt[1][k]);
      end
    end
  endtask

  task automatic test_burst();
    int n = 0;
    dly[0] = 2;
    for (int i = 0; i < 6; i++) push_byte(0, 1, 8'(8'hB0 + i));
    exp_hdr(0, 1);
    for (int i = 0; i < 4; i++) exp_byte(0, 1, 8'(8'hB0 + i));
    exp_hdr(0, 0);
    exp_byte(0, 0, 8'hC0);
    exp_hdr(0, 1);
    for (int i = 4; i < 6; i++) exp_byte(0, 1, 8'(8'hB0 + i));
    while (grant[0] !== 4'b0010 && n < 20) begin
      tick();
      n++;
    end
    nchk++;
    if (grant[0] !== 4'b0010) begin
      nfail++;
      $display("FAIL burst_first_grant: grant=%b, required 0010", grant[0]);
    end
    push_byte(0, 0, 8'hC0);
    wait_done(0, 300, "burst");
  endtask

  task automatic test_timeout();
    int k = 0;
    dly[0] = 0;
    push_byte(0, 3, 8'h77);
    wait_valid(0, "timeout");
    clear_prod(0);
    while (!tmo[0] && k < 40) begin
      tick();
      k++;
    end
    nchk++;
    if (!tmo[0] || k != 16) begin
      nfail++;
      $display("FAIL timeout_delay: pulse=%b after %0d cycles, required pulse after 16", tmo[0], k);
    end
    nchk++;
    if ({tx_valid[0], busy[0], grant[0]} !== 6'd0) begin
      nfail++;
      $display("FAIL timeout_state: valid=%b busy=%b grant=%b, required 0 0 0000", tx_valid[0], busy[0], grant[0]);
    end
    tick();
    nchk++;
    if (tmo[0] !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_pulse_width: tmo=%b one cycle later, required 0", tmo[0]);
    end
    wait_done(0, 50, "timeout");
  endtask

  task automatic test_reset_wait();
    dly[0] = 0;
    push_byte(0, 1, 8'h99);
    wait_valid(0, "reset_wait");
    clear_prod(0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    nchk++;
    if ({req_ready[0], tx_data[0], tx_valid[0], grant[0], busy[0], tmo[0]} !== 19'd0) begin
      nfail++;
      $display("FAIL reset_wait_outputs: req_ready=%b data=%h valid=%b grant=%b busy=%b tmo=%b, required all 0",
               req_ready[0], tx_data[0], tx_valid[0], grant[0], busy[0], tmo[0]);
    end
    rst = 1'b0;
    dly[0] = 2;
    push_byte(0, 2, 8'h22);
    push_byte(0, 0, 8'h0C);
    exp_hdr(0, 0);
    exp_byte(0, 0, 8'h0C);
    exp_hdr(0, 2);
    exp_byte(0, 2, 8'h22);
    wait_done(0, 200, "reset_wait");
  endtask

  task automatic test_back_to_back();
    int base = rr_cnt[0][0];
    dly[0] = 1;
    for (int i = 0; i < 3; i++) push_byte(0, 0, 8'(8'hD0 + i));
    for (int i = 0; i < 2; i++) push_byte(0, 2, 8'(8'hE0 + i));
    exp_hdr(0, 0);
    for (int i = 0; i < 3; i++) exp_byte(0, 0, 8'(8'hD0 + i));
    exp_hdr(0, 2);
    for (int i = 0; i < 2; i++) exp_byte(0, 2, 8'(8'hE0 + i));
    wait_done(0, 200, "back_to_back");
    nchk++;
    if (rr_cnt[0][0] - base != 3) begin
      nfail++;
      $display("FAIL b2b_req_ready_count: %0d pulses, required 3", rr_cnt[0][0] - base);
    end
  endtask

`ifdef UART_ARB_HDR_EN
  task automatic test_header();
    int base = rr_cnt[0][3];
    dly[0] = 2;
    push_byte(0, 3, 8'h41);
    exp_hdr(0, 3);
    exp_byte(0, 3, 8'h41);
    wait_done(0, 100, "header");
    nchk++;
    if (rr_cnt[0][3] - base != 1) begin
      nfail++;
      $display("FAIL header_req_ready_count: %0d pulses, required 1", rr_cnt[0][3] - base);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        ph[d][k] = 0;
        pt[d][k] = 0;
        rr_cnt[d][k] = 0;
      end
      pend[d] = 4'b0;
      dly[d] = 0;
      wcnt[d] = 0;
      tx_ready[d] = 1'b0;
      req_valid[d] = 4'b0;
      req_data[d] = 32'b0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
`ifdef UART_ARB_HDR_EN
    test_header();
`endif
    nchk++;
    if (expq.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_leftover: %0d bytes never sent, required 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
